// File: rtl/pkt_centralized_write_pkg.sv
// Shared definitions for the centralized packet-RAM writer: word types, FSM states,
// word field offsets and the {bufid, line} RAM address split.
package pkt_centralized_write_pkg;

  localparam int PKT_W   = 134;
  localparam int BUFID_W = 9;
  localparam int LINE_W  = 7;
  localparam int ADDR_W  = BUFID_W + LINE_W;

  localparam int TYPE_HI = 133;
  localparam int TYPE_LO = 132;
  localparam int INV_HI  = 131;
  localparam int INV_LO  = 128;
  localparam int DATA_HI = 127;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    W_MID    = 2'b00,
    W_FIRST  = 2'b01,
    W_LAST   = 2'b10,
    W_SINGLE = 2'b11
  } word_type_e;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_BUFID = 2'd1,
    S_WRITE      = 2'd2,
    S_DISCARD    = 2'd3
  } state_e;

endpackage

// File: rtl/pkt_centralized_write_sync_fifo.sv
// Show-ahead synchronous FIFO: head word visible the cycle after it is pushed;
// push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    usedw_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign usedw_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_centralized_write.sv
// Writes parser frames into packet RAM at {bufid, line}; a queued word can request the cycle
// after it is pushed; the RAM port holds req/addr/data until ack, input overruns are dropped.
module pkt_centralized_write
  import pkt_centralized_write_pkg::*;
#(
  parameter logic [3:0] inport           = 4'b0000,
  parameter int         DATA_FIFO_DEPTH  = 16,
  parameter int         BUFID_FIFO_DEPTH = 4,
  parameter int         MAX_LINES        = 128
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [PKT_W-1:0]   iv_pkt,
  input  logic               i_pkt_wr,
  input  logic               i_pkt_bufid_wr,
  input  logic [BUFID_W-1:0] iv_pkt_bufid,
  output logic               o_ram_wr_req,
  output logic [ADDR_W-1:0]  ov_ram_waddr,
  output logic [PKT_W-1:0]   ov_ram_wdata,
  input  logic               i_ram_wr_ack,
  output logic               o_done_wr,
  output logic [BUFID_W-1:0] ov_done_bufid,
  output logic [7:0]         ov_done_lines,
  output logic               o_done_err,
  output logic [3:0]         ov_done_port,
  output logic               o_data_ovf_pulse,
  output logic               o_bufid_ovf_pulse,
  output logic               o_orphan_pulse,
  output logic [1:0]         pkt_write_state
);
  logic [1:0]                          rst_sync_q;
  logic                                rst_n_int;
  logic [PKT_W-1:0]                    d_head;
  logic                                d_full, d_empty, d_pop;
  logic [$clog2(DATA_FIFO_DEPTH):0]    d_usedw;
  logic [BUFID_W-1:0]                  b_head;
  logic                                b_full, b_empty, b_pop;
  logic [$clog2(BUFID_FIFO_DEPTH):0]   b_usedw;
  logic                                levels_unused;
  word_type_e                          head_type;
  logic                                head_first, head_last;
  logic                                ram_req, missing_tail;
  state_e                              state_q;
  logic [BUFID_W-1:0]                  bufid_q;
  logic [LINE_W-1:0]                   line_q;
  logic                                done_wr_q, done_err_q;
  logic [BUFID_W-1:0]                  done_bufid_q;
  logic [7:0]                          done_lines_q;
  logic                                data_ovf_q, bufid_ovf_q, orphan_q;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  sync_fifo #(.WIDTH(PKT_W), .DEPTH(DATA_FIFO_DEPTH)) u_data_fifo (
    .clk_i(clk_sys), .rst_n_i(rst_n_int), .push_i(i_pkt_wr), .data_i(iv_pkt), .pop_i(d_pop),
    .data_o(d_head), .full_o(d_full), .empty_o(d_empty), .usedw_o(d_usedw)
  );

  sync_fifo #(.WIDTH(BUFID_W), .DEPTH(BUFID_FIFO_DEPTH)) u_bufid_fifo (
    .clk_i(clk_sys), .rst_n_i(rst_n_int), .push_i(i_pkt_bufid_wr), .data_i(iv_pkt_bufid),
    .pop_i(b_pop), .data_o(b_head), .full_o(b_full), .empty_o(b_empty), .usedw_o(b_usedw)
  );

  assign levels_unused = ^{d_usedw, b_usedw};
  assign head_type     = word_type_e'(d_head[TYPE_HI:TYPE_LO]);
  assign head_first    = (head_type == W_FIRST) || (head_type == W_SINGLE);
  assign head_last     = (head_type == W_LAST)  || (head_type == W_SINGLE);

  // A first-type head past line 0 belongs to the next frame: close this one without writing it.
  always_comb begin
    ram_req      = 1'b0;
    missing_tail = 1'b0;
    d_pop        = 1'b0;
    b_pop        = 1'b0;
    case (state_q)
      S_IDLE: if (!d_empty) begin
        if (!head_first)   d_pop = 1'b1;
        else if (!b_empty) b_pop = 1'b1;
      end
      S_WAIT_BUFID: b_pop = !b_empty;
      S_WRITE: if (!d_empty) begin
        if (head_first && (line_q != '0)) begin
          missing_tail = 1'b1;
        end else begin
          ram_req = 1'b1;
          d_pop   = i_ram_wr_ack;
        end
      end
      S_DISCARD: d_pop = !d_empty && !head_first;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= S_IDLE;
      bufid_q      <= '0;
      line_q       <= '0;
      done_wr_q    <= 1'b0;
      done_bufid_q <= '0;
      done_lines_q <= '0;
      done_err_q   <= 1'b0;
      data_ovf_q   <= 1'b0;
      bufid_ovf_q  <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      done_wr_q   <= 1'b0;
      orphan_q    <= 1'b0;
      data_ovf_q  <= i_pkt_wr && d_full && !d_pop;
      bufid_ovf_q <= i_pkt_bufid_wr && b_full && !b_pop;
      case (state_q)
        S_IDLE: if (!d_empty) begin
          if (!head_first) begin
            orphan_q <= 1'b1;
          end else if (!b_empty) begin
            bufid_q <= b_head;
            line_q  <= '0;
            state_q <= S_WRITE;
          end else begin
            state_q <= S_WAIT_BUFID;
          end
        end
        S_WAIT_BUFID: if (!b_empty) begin
          bufid_q <= b_head;
          line_q  <= '0;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (missing_tail) begin
            done_wr_q    <= 1'b1;
            done_bufid_q <= bufid_q;
            done_lines_q <= {1'b0, line_q};
            done_err_q   <= 1'b1;
            state_q      <= S_IDLE;
          end else if (ram_req && i_ram_wr_ack) begin
            line_q <= line_q + 1'b1;
            if (head_last) begin
              done_wr_q    <= 1'b1;
              done_bufid_q <= bufid_q;
              done_lines_q <= {1'b0, line_q} + 8'd1;
              done_err_q   <= 1'b0;
              state_q      <= S_IDLE;
            end else if (line_q == LINE_W'(MAX_LINES - 1)) begin
              done_wr_q    <= 1'b1;
              done_bufid_q <= bufid_q;
              done_lines_q <= 8'(MAX_LINES);
              done_err_q   <= 1'b1;
              state_q      <= S_DISCARD;
            end
          end
        end
        S_DISCARD: if (!d_empty && (head_first || head_last)) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ram_wr_req      = ram_req;
  assign ov_ram_waddr      = {bufid_q, line_q};
  assign ov_ram_wdata      = ram_req ? {d_head[TYPE_HI:TYPE_LO], d_head[INV_HI:INV_LO],
                                        d_head[DATA_HI:DATA_LO]} : '0;
  assign o_done_wr         = done_wr_q;
  assign ov_done_bufid     = done_bufid_q;
  assign ov_done_lines     = done_lines_q;
  assign o_done_err        = done_err_q;
  assign ov_done_port      = inport;
  assign o_data_ovf_pulse  = data_ovf_q;
  assign o_bufid_ovf_pulse = bufid_ovf_q;
  assign o_orphan_pulse    = orphan_q;
  assign pkt_write_state   = state_q;

endmodule

// File: tb/tb_pkt_centralized_write.sv
// Directed bench for pkt_centralized_write: hand-computed RAM addresses, data and done reports.
`timescale 1ns/1ps
module tb_pkt_centralized_write;
  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic [133:0] iv_pkt;
  logic         i_pkt_wr, i_pkt_bufid_wr, i_ram_wr_ack;
  logic [8:0]   iv_pkt_bufid;
  logic         o_ram_wr_req, o_done_wr, o_done_err;
  logic [15:0]  ov_ram_waddr;
  logic [133:0] ov_ram_wdata;
  logic [8:0]   ov_done_bufid;
  logic [7:0]   ov_done_lines;
  logic [3:0]   ov_done_port;
  logic         o_data_ovf_pulse, o_bufid_ovf_pulse, o_orphan_pulse;
  logic [1:0]   pkt_write_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int orphans = 0;
  logic [15:0]  wa_q[$];
  logic [133:0] wd_q[$];
  int           wc_q[$];
  logic [8:0]   db_q[$];
  logic [7:0]   dl_q[$];
  logic         de_q[$];

  pkt_centralized_write dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .iv_pkt(iv_pkt), .i_pkt_wr(i_pkt_wr),
    .i_pkt_bufid_wr(i_pkt_bufid_wr), .iv_pkt_bufid(iv_pkt_bufid),
    .o_ram_wr_req(o_ram_wr_req), .ov_ram_waddr(ov_ram_waddr), .ov_ram_wdata(ov_ram_wdata),
    .i_ram_wr_ack(i_ram_wr_ack), .o_done_wr(o_done_wr), .ov_done_bufid(ov_done_bufid),
    .ov_done_lines(ov_done_lines), .o_done_err(o_done_err), .ov_done_port(ov_done_port),
    .o_data_ovf_pulse(o_data_ovf_pulse), .o_bufid_ovf_pulse(o_bufid_ovf_pulse),
    .o_orphan_pulse(o_orphan_pulse), .pkt_write_state(pkt_write_state)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (o_ram_wr_req && i_ram_wr_ack) begin
      wa_q.push_back(ov_ram_waddr);
      wd_q.push_back(ov_ram_wdata);
      wc_q.push_back(cyc);
    end
    if (o_done_wr) begin
      db_q.push_back(ov_done_bufid);
      dl_q.push_back(ov_done_lines);
      de_q.push_back(o_done_err);
    end
    if (o_orphan_pulse) orphans++;
  end

  function automatic logic [133:0] mkw(input logic [1:0] t, input int idx);
    return {t, 4'h0, {4{32'(idx) ^ 32'hC0DE_0000}}};
  endfunction

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_word(input logic [1:0] t, input int idx);
    i_pkt_wr = 1'b1;
    iv_pkt   = mkw(t, idx);
    tick();
    i_pkt_wr = 1'b0;
  endtask

  task automatic push_bufid(input logic [8:0] b);
    i_pkt_bufid_wr = 1'b1;
    iv_pkt_bufid   = b;
    tick();
    i_pkt_bufid_wr = 1'b0;
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    db_q.delete(); dl_q.delete(); de_q.delete();
    orphans = 0;
  endtask

  task automatic wait_done(input int n, input int max_cyc, input string tag);
    int k = 0;
    while (db_q.size() < n && k < max_cyc) begin
      tick();
      k++;
    end
    chk(tag, 134'(db_q.size() >= n), 134'd1);
  endtask

  initial begin
    reset_n = 1'b0; iv_pkt = '0; i_pkt_wr = 1'b0; i_pkt_bufid_wr = 1'b0;
    iv_pkt_bufid = '0; i_ram_wr_ack = 1'b0;
    repeat (3) tick();
    chk("rst_req", o_ram_wr_req, 0);
    chk("rst_waddr", ov_ram_waddr, 0);
    chk("rst_wdata", ov_ram_wdata, 0);
    chk("rst_done", {o_done_wr, o_done_err, ov_done_bufid, ov_done_lines}, 0);
    chk("rst_port", ov_done_port, 0);
    chk("rst_pulses", {o_data_ovf_pulse, o_bufid_ovf_pulse, o_orphan_pulse}, 0);
    chk("rst_state", pkt_write_state, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // 3-word frame, ack always high: back-to-back writes at 0x0280..0x0282
    i_ram_wr_ack = 1'b1;
    clear_logs();
    push_bufid(9'h005);
    push_word(2'b01, 0); push_word(2'b00, 1); push_word(2'b10, 2);
    wait_done(1, 20, "t1_done_seen");
    chk("t1_nwr", wa_q.size(), 3);
    chk("t1_a0", wa_q[0], 16'h0280);
    chk("t1_a1", wa_q[1], 16'h0281);
    chk("t1_a2", wa_q[2], 16'h0282);
    chk("t1_d0", wd_q[0], mkw(2'b01, 0));
    chk("t1_d2", wd_q[2], mkw(2'b10, 2));
    chk("t1_gap01", wc_q[1] - wc_q[0], 1);
    chk("t1_gap12", wc_q[2] - wc_q[1], 1);
    chk("t1_bufid", db_q[0], 9'h005);
    chk("t1_lines", dl_q[0], 3);
    chk("t1_err", de_q[0], 0);

    // frame arrives before its bufid: WAIT_BUFID for 10 cycles
    clear_logs();
    push_word(2'b01, 10);
    for (int i = 0; i < 9; i++) begin
      if (i < 2) begin
        i_pkt_wr = 1'b1;
        iv_pkt   = mkw((i == 1) ? 2'b10 : 2'b00, 11 + i);
      end
      tick();
      i_pkt_wr = 1'b0;
      chk("t2_wait_state", pkt_write_state, 1);
    end
    push_bufid(9'h1FF);
    chk("t2_wait_state_last", pkt_write_state, 1);
    wait_done(1, 20, "t2_done_seen");
    chk("t2_nwr", wa_q.size(), 3);
    chk("t2_a0", wa_q[0], 16'hFF80);
    chk("t2_a2", wa_q[2], 16'hFF82);
    chk("t2_d0", wd_q[0], mkw(2'b01, 10));
    chk("t2_d1", wd_q[1], mkw(2'b00, 11));
    chk("t2_d2", wd_q[2], mkw(2'b10, 12));
    chk("t2_done", {db_q[0], dl_q[0], de_q[0]}, {9'h1FF, 8'd3, 1'b0});

    // ack toggling 1,0,1,0: port holds on ack=0 cycles
    i_ram_wr_ack = 1'b0;
    clear_logs();
    push_bufid(9'h007);
    push_word(2'b01, 20); push_word(2'b00, 21); push_word(2'b00, 22); push_word(2'b10, 23);
    chk("t3_req_up", o_ram_wr_req, 1);
    chk("t3_addr0", ov_ram_waddr, 16'h0380);
    for (int k = 0; k < 8; k++) begin
      logic [15:0]  a;
      logic [133:0] d;
      logic         r;
      i_ram_wr_ack = (k % 2 == 0);
      a = ov_ram_waddr; d = ov_ram_wdata; r = o_ram_wr_req;
      tick();
      if (!i_ram_wr_ack && r) begin
        chk("t3_hold_req", o_ram_wr_req, 1);
        chk("t3_hold_addr", ov_ram_waddr, a);
        chk("t3_hold_data", ov_ram_wdata, d);
      end
    end
    i_ram_wr_ack = 1'b1;
    wait_done(1, 10, "t3_done_seen");
    chk("t3_nwr", wa_q.size(), 4);
    chk("t3_a3", wa_q[3], 16'h0383);
    chk("t3_d3", wd_q[3], mkw(2'b10, 23));
    chk("t3_done", {db_q[0], dl_q[0], de_q[0]}, {9'h007, 8'd4, 1'b0});

    // 130-word frame: 128 lines written, rest discarded
    clear_logs();
    push_bufid(9'h010);
    for (int i = 0; i < 130; i++)
      push_word((i == 0) ? 2'b01 : ((i == 129) ? 2'b10 : 2'b00), 100 + i);
    wait_done(1, 40, "t4_done_seen");
    repeat (4) tick();
    chk("t4_nwr", wa_q.size(), 128);
    chk("t4_afirst", wa_q[0], 16'h0800);
    chk("t4_alast", wa_q[127], 16'h087F);
    chk("t4_dlast", wd_q[127], mkw(2'b00, 227));
    chk("t4_done", {db_q[0], dl_q[0], de_q[0]}, {9'h010, 8'd128, 1'b1});
    chk("t4_idle", pkt_write_state, 0);
    chk("t4_req_low", o_ram_wr_req, 0);
    chk("t4_orphans", orphans, 0);

    // missing tail: first frame closed with err, single-word frame follows
    clear_logs();
    push_bufid(9'h002); push_bufid(9'h003);
    push_word(2'b01, 30); push_word(2'b00, 31); push_word(2'b11, 32);
    wait_done(2, 30, "t5_done_seen");
    chk("t5_done0", {db_q[0], dl_q[0], de_q[0]}, {9'h002, 8'd2, 1'b1});
    chk("t5_done1", {db_q[1], dl_q[1], de_q[1]}, {9'h003, 8'd1, 1'b0});
    chk("t5_nwr", wa_q.size(), 3);
    chk("t5_a1", wa_q[1], 16'h0101);
    chk("t5_a2", wa_q[2], 16'h0180);
    chk("t5_d2", wd_q[2], mkw(2'b11, 32));

    // orphan middle word in IDLE
    clear_logs();
    push_word(2'b00, 40);
    repeat (3) tick();
    chk("t5_orphan", orphans, 1);
    chk("t5_orphan_nwr", wa_q.size(), 0);

    // overflows with ack held low, then reset mid-frame
    i_ram_wr_ack = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      push_bufid(9'(32 + i));
      if (i == 3) chk("t6_bovf_4th", o_bufid_ovf_pulse, 0);
    end
    chk("t6_bovf_5th", o_bufid_ovf_pulse, 1);
    for (int i = 0; i < 17; i++) begin
      push_word((i == 0) ? 2'b01 : 2'b00, 50 + i);
      if (i == 0)  chk("t6_bovf_clear", o_bufid_ovf_pulse, 0);
      if (i == 15) chk("t6_dovf_16th", o_data_ovf_pulse, 0);
    end
    chk("t6_dovf_17th", o_data_ovf_pulse, 1);
    tick();
    chk("t6_dovf_clear", o_data_ovf_pulse, 0);
    chk("t6_state", pkt_write_state, 2);
    chk("t6_req", o_ram_wr_req, 1);
    chk("t6_addr", ov_ram_waddr, 16'h1000);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", o_ram_wr_req, 0);
    chk("t6_rst_waddr", ov_ram_waddr, 0);
    chk("t6_rst_wdata", ov_ram_wdata, 0);
    chk("t6_rst_state", pkt_write_state, 0);
    chk("t6_rst_pulses", {o_done_wr, o_data_ovf_pulse, o_bufid_ovf_pulse, o_orphan_pulse}, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    i_ram_wr_ack = 1'b1;
    push_bufid(9'h009);
    push_word(2'b11, 60);
    wait_done(1, 20, "t6_post_done_seen");
    chk("t6_post_ndone", db_q.size(), 1);
    chk("t6_post_nwr", wa_q.size(), 1);
    chk("t6_post_addr", wa_q[0], 16'h0480);
    chk("t6_post_done", {db_q[0], dl_q[0], de_q[0]}, {9'h009, 8'd1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_centralized_write.md
Name: pkt_centralized_write

Overview:
- Downstream of the frame parser: consumes its 134-bit packet words (ov_pkt/o_pkt_wr) and its buffer-id stream (o_pkt_bufid_wr/ov_pkt_bufid).
- Writes each frame into the centralized packet RAM at address {bufid, line} via a req/ack write port shared with other ports' writers.
- Decouples parser timing from arbiter grants with a small data FIFO and a bufid FIFO.
- Reports completion, frame errors and overflows.

Parameters:
- inport, 4'b0000, input port number, echoed in ov_done_port.
- DATA_FIFO_DEPTH, 16, data FIFO depth in words (power of 2).
- BUFID_FIFO_DEPTH, 4, bufid FIFO depth (power of 2).
- MAX_LINES, 128, maximum 16-byte lines per buffer; line index is 7 bits.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- iv_pkt  in  134  packet word:
  - [133:132] 01 first, 00 middle, 10 last, 11 first+last;
  - [131:128] invalid byte count (last word only);
  - [127:0] data.
- i_pkt_wr  in  1  iv_pkt valid.
- i_pkt_bufid_wr  in  1  iv_pkt_bufid valid.
- iv_pkt_bufid  in  9  buffer id for the next frame.
- o_ram_wr_req  out  1  RAM write request.
- ov_ram_waddr  out  16  {bufid[8:0], line[6:0]}.
- ov_ram_wdata  out  134  word to write.
- i_ram_wr_ack  in  1  arbiter accepted the current word.
- o_done_wr  out  1  one-cycle frame completion pulse.
- ov_done_bufid  out  9  bufid of the completed frame.
- ov_done_lines  out  8  words written (1..128).
- o_done_err  out  1  frame truncated or overlong.
- ov_done_port  out  4  equals inport.
- o_data_ovf_pulse  out  1  word dropped, data FIFO full.
- o_bufid_ovf_pulse  out  1  bufid dropped, bufid FIFO full.
- o_orphan_pulse  out  1  non-first word dropped in IDLE.
- pkt_write_state  out  2  FSM state.

Behaviour:
- Reset: all outputs 0, FSM IDLE, both FIFOs empty, line counter 0.
- Async assert; deassertion is synchronous to clk_sys. Reset mid-frame discards everything with no done pulse.
- FIFOs are show-ahead with registered output.
  - Push and pop in the same cycle is legal at any fill level, including full.
  - A push while full (and not popping) drops the input and pulses the matching ovf output for one cycle.
- Latency: word pushed at cycle N yields earliest o_ram_wr_req at N+1.
- Handshake: o_ram_wr_req, ov_ram_waddr and ov_ram_wdata stay stable until the cycle i_ram_wr_ack=1.
  - The word is popped on ack.
  - Ack may arrive in the same cycle req rises.
  - Ack while req=0 is ignored.
- FSM, encoded IDLE=0, WAIT_BUFID=1, WRITE=2, DISCARD=3:
  - IDLE, data FIFO head not first-type: pop and drop it, pulse o_orphan_pulse.
  - IDLE, head first-type: if the bufid FIFO is non-empty, pop bufid, set line=0, go WRITE; else go WAIT_BUFID.
  - WAIT_BUFID: pop bufid when available, go WRITE. Data words keep queueing.
  - WRITE, per acked word: line+1.
    - Acked word is last-type or first+last: pulse o_done_wr with lines=line+1 and err=0, go IDLE.
    - A first-type word at the head other than the frame's opening word (missing tail) is not written. Pulse done with lines=line and err=1, go IDLE; that word then starts the next frame.
    - Acked word at line=MAX_LINES-1 that is not last: done with lines=128 and err=1, go DISCARD.
  - DISCARD: pop and drop without request until a last-type word is popped, then go IDLE.
    - A first-type head exits to IDLE without popping.
- Bufid and frame pairing is strictly FIFO order. A frame never consumes more than one bufid.
- ov_done_port is constant inport.

Decomposition:
- Shared package holds:
  - word-type codes FIRST, MID, LAST, SINGLE;
  - the state encodings;
  - field offsets 133:132, 131:128, 127:0;
  - address split 9+7.
- One sub-module, sync_fifo, parameterized by width and depth, with show-ahead output, full, empty and usedw. Instantiated twice: 134 x 16 and 9 x 4.

Test Plan:
- Bufid 0x05 pushed, then a 3-word frame (01, 00, 10), ack always 1 -> waddr 0x0280, 0x0281, 0x0282 on consecutive cycles; done with bufid 5, lines 3, err 0.
- Frame first, bufid 0x1FF pushed 10 cycles later -> state WAIT_BUFID for 10 cycles; writes start at 0xFF80; no data lost.
- Ack toggles 1,0,1,0 during a 4-word frame -> req, addr and data hold on ack=0 cycles; exactly 4 writes; done lines 4.
- 130-word frame (no last by line 127) -> 128 writes (0x..00-0x..7F); done err 1, lines 128; remaining 2 words dropped, state returns IDLE.
- Frame 01,00 then a new 11 frame, bufids 2 and 3 -> done(2, lines 2, err 1), then done(3, lines 1, err 0) at address 0x0180.
- Ack held 0, 17 words pushed -> o_data_ovf_pulse on the 17th; 5 bufids pushed -> o_bufid_ovf_pulse on the 5th; reset_n low mid-frame -> all outputs 0 immediately.
